// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb memory arbiter.
// Enable the fetch-fairness rule by defining MEM_ARB_FAIR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned FAIR_LIMIT = 2;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the RAM access window.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic             CLOCK,
  input  logic             in_rst,
  input  logic             in_load,
  input  logic [CNT_W-1:0] in_load_val,
  input  logic             in_dec,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= only, so every register in
  // this block samples the pre-edge value of every other register.
  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      r_cnt <= '0;
    end else if (in_load) begin
      r_cnt <= in_load_val;
    end else if (in_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign out_cnt  = r_cnt;
  assign out_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arb.sv
// Single-port RAM arbiter between instruction fetch and MEM-stage loads/stores.
// Optional fetch-fairness rule is compiled in when MEM_ARB_FAIR_EN is defined.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT = 2,
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16
) (
  input  logic          CLOCK,
  input  logic          in_rst,
  input  logic          in_if_req,
  input  logic [AW-1:0] in_if_addr,
  output logic [DW-1:0] out_if_data,
  output logic          out_if_ack,
  input  logic          in_cntrl_mem_read,
  input  logic          in_cntrl_mem_write,
  input  logic [AW-1:0] in_addr_mem,
  input  logic [DW-1:0] in_data_mem,
  output logic [DW-1:0] out_mem_rdata,
  output logic          out_mem_ack,
  output logic          out_stall,
  output logic          out_ram_en,
  output logic          out_ram_we,
  output logic [AW-1:0] out_ram_addr,
  output logic [DW-1:0] out_ram_wdata,
  input  logic [DW-1:0] in_ram_rdata
);

  state_t           r_state;
  owner_t           r_owner;
  logic             r_store;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_ram_en;
  logic             r_ram_we;
  logic             r_if_ack;
  logic             r_mem_ack;
  logic [DW-1:0]    r_if_data;
  logic [DW-1:0]    r_mem_rdata;

  logic             w_dreq;
  logic             w_start;
  logic             w_grant_dm;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic [CNT_W-1:0] w_wait_m1;

  assign w_dreq    = in_cntrl_mem_read | in_cntrl_mem_write;
  assign w_start   = (r_state == ST_IDLE) && (w_dreq || in_if_req);
  assign w_wait_m1 = CNT_W'(WAIT - 1);

`ifdef MEM_ARB_FAIR_EN
  logic [1:0] r_fair_cnt;
  logic       w_fair_force;

  assign w_fair_force = in_if_req && w_dreq && (r_fair_cnt == 2'(FAIR_LIMIT));
  assign w_grant_dm   = w_dreq && !w_fair_force;

  // Counts data grants that overtook a pending fetch; any fetch grant or an
  // idle fetch side restarts the run.
  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      r_fair_cnt <= '0;
    end else if (w_start) begin
      if (!in_if_req || !w_grant_dm) r_fair_cnt <= '0;
      else                           r_fair_cnt <= r_fair_cnt + 1'b1;
    end
  end
`else
  assign w_grant_dm = w_dreq;
`endif

  mem_arb_wait_cnt u_wait_cnt (
    .CLOCK       (CLOCK),
    .in_rst      (in_rst),
    .in_load     (w_start),
    .in_load_val (w_wait_m1),
    .in_dec      (r_state == ST_ACC),
    .out_cnt     (w_cnt),
    .out_zero    (w_zero)
  );

  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_store     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_owner  <= w_grant_dm ? OWN_DM : OWN_IF;
            r_store  <= w_grant_dm && in_cntrl_mem_write;
            r_addr   <= w_grant_dm ? in_addr_mem : in_if_addr;
            r_wdata  <= in_data_mem;
            r_ram_en <= 1'b1;
            // The write strobe is registered, so it is set one edge early.
            r_ram_we <= w_grant_dm && in_cntrl_mem_write && (WAIT == 1);
            r_state  <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (w_zero) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            if (r_owner == OWN_IF) begin
              r_if_data <= in_ram_rdata;
              r_if_ack  <= 1'b1;
            end else begin
              if (!r_store) r_mem_rdata <= in_ram_rdata;
              r_mem_ack <= 1'b1;
            end
            r_state <= ST_ACK;
          end else begin
            r_ram_we <= r_store && (w_cnt == CNT_W'(1));
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_stall     = w_dreq & ~r_mem_ack;
  assign out_ram_en    = r_ram_en;
  assign out_ram_we    = r_ram_we;
  assign out_ram_addr  = r_addr;
  assign out_ram_wdata = r_wdata;
  assign out_if_ack    = r_if_ack;
  assign out_if_data   = r_if_data;
  assign out_mem_ack   = r_mem_ack;
  assign out_mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb (WAIT=2); expected grant order
// follows MEM_ARB_FAIR_EN.
module tb_mem_arb;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned WAIT = 2;

  logic          CLOCK = 1'b0;
  logic          in_rst;
  logic          in_if_req;
  logic [AW-1:0] in_if_addr;
  logic [DW-1:0] out_if_data;
  logic          out_if_ack;
  logic          in_cntrl_mem_read;
  logic          in_cntrl_mem_write;
  logic [AW-1:0] in_addr_mem;
  logic [DW-1:0] in_data_mem;
  logic [DW-1:0] out_mem_rdata;
  logic          out_mem_ack;
  logic          out_stall;
  logic          out_ram_en;
  logic          out_ram_we;
  logic [AW-1:0] out_ram_addr;
  logic [DW-1:0] out_ram_wdata;
  logic [DW-1:0] in_ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  mem_arb #(.WAIT(WAIT), .AW(AW), .DW(DW)) dut (
    .CLOCK              (CLOCK),
    .in_rst             (in_rst),
    .in_if_req          (in_if_req),
    .in_if_addr         (in_if_addr),
    .out_if_data        (out_if_data),
    .out_if_ack         (out_if_ack),
    .in_cntrl_mem_read  (in_cntrl_mem_read),
    .in_cntrl_mem_write (in_cntrl_mem_write),
    .in_addr_mem        (in_addr_mem),
    .in_data_mem        (in_data_mem),
    .out_mem_rdata      (out_mem_rdata),
    .out_mem_ack        (out_mem_ack),
    .out_stall          (out_stall),
    .out_ram_en         (out_ram_en),
    .out_ram_we         (out_ram_we),
    .out_ram_addr       (out_ram_addr),
    .out_ram_wdata      (out_ram_wdata),
    .in_ram_rdata       (in_ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    logic [3:0] order;
    logic [3:0] exp_order;
    int         n_grants;
    int         n_dm;

    order    = 4'b0000;
    n_grants = 0;
    n_dm     = 0;

    in_rst             = 1'b0;
    in_if_req          = 1'b0;
    in_if_addr         = '0;
    in_cntrl_mem_read  = 1'b0;
    in_cntrl_mem_write = 1'b0;
    in_addr_mem        = '0;
    in_data_mem        = '0;
    in_ram_rdata       = '0;

    // Reset state
    step();
    step();
    check("rst_en",     out_ram_en,    1'b0);
    check("rst_we",     out_ram_we,    1'b0);
    check("rst_if_ack", out_if_ack,    1'b0);
    check("rst_mack",   out_mem_ack,   1'b0);
    check("rst_stall",  out_stall,     1'b0);
    check("rst_addr",   out_ram_addr,  16'h0000);
    check("rst_mrdata", out_mem_rdata, 16'h0000);
    #2 in_rst = 1'b1;
    step();

    // Fetch only
    in_if_req    = 1'b1;
    in_if_addr   = 16'h0010;
    in_ram_rdata = 16'h1234;
    step();
    check("f_en1",    out_ram_en,   1'b1);
    check("f_addr1",  out_ram_addr, 16'h0010);
    check("f_we1",    out_ram_we,   1'b0);
    check("f_stall",  out_stall,    1'b0);
    step();
    check("f_en2",    out_ram_en,   1'b1);
    check("f_ack2",   out_if_ack,   1'b0);
    step();
    check("f_ack",    out_if_ack,   1'b1);
    check("f_data",   out_if_data,  16'h1234);
    check("f_en3",    out_ram_en,   1'b0);
    in_if_req    = 1'b0;
    in_ram_rdata = 16'h0000;
    step();
    check("f_ack_end", out_if_ack,  1'b0);
    check("f_hold",    out_if_data, 16'h1234);

    // Contention: load beats fetch, fetch served right after
    in_cntrl_mem_read = 1'b1;
    in_addr_mem       = 16'h0002;
    in_if_req         = 1'b1;
    in_if_addr        = 16'h0020;
    in_ram_rdata      = 16'hBEEF;
    #1 check("c_stall0", out_stall, 1'b1);
    step();
    check("c_addr1",  out_ram_addr, 16'h0002);
    check("c_en1",    out_ram_en,   1'b1);
    check("c_stall1", out_stall,    1'b1);
    step();
    check("c_en2",    out_ram_en,   1'b1);
    step();
    check("c_mack",   out_mem_ack,   1'b1);
    check("c_mdata",  out_mem_rdata, 16'hBEEF);
    check("c_fack",   out_if_ack,    1'b0);
    check("c_stall3", out_stall,     1'b0);
    in_cntrl_mem_read = 1'b0;
    in_ram_rdata      = 16'h5A5A;
    step();
    check("c_idle_en", out_ram_en, 1'b0);
    step();
    check("c_f_en",   out_ram_en,   1'b1);
    check("c_f_addr", out_ram_addr, 16'h0020);
    step();
    step();
    check("c_f_ack",  out_if_ack,  1'b1);
    check("c_f_data", out_if_data, 16'h5A5A);
    in_if_req = 1'b0;
    step();

    // Store
    in_cntrl_mem_write = 1'b1;
    in_addr_mem        = 16'h0002;
    in_data_mem        = 16'h0004;
    #1 check("s_stall0", out_stall, 1'b1);
    step();
    check("s_en1",    out_ram_en, 1'b1);
    check("s_we1",    out_ram_we, 1'b0);
    check("s_stall1", out_stall,  1'b1);
    step();
    check("s_we2",    out_ram_we,    1'b1);
    check("s_addr2",  out_ram_addr,  16'h0002);
    check("s_wdata2", out_ram_wdata, 16'h0004);
    check("s_stall2", out_stall,     1'b1);
    step();
    check("s_mack",   out_mem_ack,   1'b1);
    check("s_we3",    out_ram_we,    1'b0);
    check("s_stall3", out_stall,     1'b0);
    check("s_rdata",  out_mem_rdata, 16'hBEEF);
    in_cntrl_mem_write = 1'b0;
    step();
    check("s_mack_end", out_mem_ack, 1'b0);

    // Fairness: three loads with a fetch held
    in_cntrl_mem_read = 1'b1;
    in_addr_mem       = 16'h0040;
    in_if_req         = 1'b1;
    in_if_addr        = 16'h0050;
    in_ram_rdata      = 16'h1111;
    for (int cyc = 0; cyc < 60 && (in_cntrl_mem_read || in_if_req); cyc++) begin
      step();
      if (out_mem_ack) begin
        if (n_grants < 4) order[n_grants] = 1'b0;
        n_grants++;
        n_dm++;
        if (n_dm == 3) in_cntrl_mem_read = 1'b0;
      end
      if (out_if_ack) begin
        if (n_grants < 4) order[n_grants] = 1'b1;
        n_grants++;
        in_if_req = 1'b0;
      end
    end
`ifdef MEM_ARB_FAIR_EN
    exp_order = 4'b0100;
`else
    exp_order = 4'b1000;
`endif
    check("fair_grants", n_grants, 4);
    check("fair_order",  order,    exp_order);
    in_cntrl_mem_read = 1'b0;
    in_if_req         = 1'b0;
    step();

    // Read and write together: performed as a store
    in_cntrl_mem_read  = 1'b1;
    in_cntrl_mem_write = 1'b1;
    in_addr_mem        = 16'h0004;
    in_data_mem        = 16'h0099;
    in_ram_rdata       = 16'hDEAD;
    step();
    check("rw_we1",   out_ram_we, 1'b0);
    step();
    check("rw_we2",   out_ram_we,    1'b1);
    check("rw_wdata", out_ram_wdata, 16'h0099);
    step();
    check("rw_mack",  out_mem_ack,   1'b1);
    check("rw_rdata", out_mem_rdata, 16'h1111);
    in_cntrl_mem_read  = 1'b0;
    in_cntrl_mem_write = 1'b0;
    step();

    // Reset during the first ACC cycle
    in_cntrl_mem_read = 1'b1;
    in_addr_mem       = 16'h0030;
    in_ram_rdata      = 16'h7777;
    step();
    check("r_pre_en", out_ram_en, 1'b1);
    in_rst = 1'b0;
    #1;
    check("r_en_async", out_ram_en,    1'b0);
    check("r_mrdata0",  out_mem_rdata, 16'h0000);
    step();
    check("r_mack_rst", out_mem_ack, 1'b0);
    #3 in_rst = 1'b1;
    step();
    check("r_en1",   out_ram_en,   1'b1);
    check("r_addr1", out_ram_addr, 16'h0030);
    check("r_mack1", out_mem_ack,  1'b0);
    step();
    check("r_en2",   out_ram_en,  1'b1);
    check("r_mack2", out_mem_ack, 1'b0);
    step();
    check("r_mack3", out_mem_ack,   1'b1);
    check("r_data3", out_mem_rdata, 16'h7777);
    in_cntrl_mem_read = 1'b0;
    step();
    check("r_mack4", out_mem_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port data-memory arbiter and access sequencer for the 16-bit pipelined processor. It shares one synchronous single-port RAM between the fetch stage (instruction reads) and the MEM stage (lw/sw requests taken from the wb_buf control and address/data outputs). It runs each access as a fixed multi-cycle transaction, returns read data with a one-cycle acknowledge, and stalls the pipeline while a data access is outstanding.

## Interface
- WAIT, 2: RAM cycles per access (legal range 1–15).
- AW, 16: address width.
- DW, 16: data width.
- CLOCK  in  1  system clock, rising-edge.
- in_rst  in  1  reset, asynchronous, active-low.
- in_if_req  in  1  fetch read request, level, held until out_if_ack.
- in_if_addr  in  AW  fetch address.
- out_if_data  out  DW  fetched word, valid while out_if_ack=1, holds afterwards.
- out_if_ack  out  1  one-cycle fetch completion pulse.
- in_cntrl_mem_read  in  1  MEM-stage load request, level.
- in_cntrl_mem_write  in  1  MEM-stage store request, level.
- in_addr_mem  in  AW  data address.
- in_data_mem  in  DW  store data.
- out_mem_rdata  out  DW  load result, valid while out_mem_ack=1, holds afterwards.
- out_mem_ack  out  1  one-cycle data completion pulse (loads and stores).
- out_stall  out  1  pipeline stall.
- out_ram_en  out  1  RAM enable.
- out_ram_we  out  1  RAM write strobe.
- out_ram_addr  out  AW  RAM address.
- out_ram_wdata  out  DW  RAM write data.
- in_ram_rdata  in  DW  RAM read data, valid in the last access cycle.

## Operation
- Data request: dreq = in_cntrl_mem_read | in_cntrl_mem_write. If both are high, the access is a store and the read is dropped.
- FSM states: IDLE, ACC, ACK.
  - IDLE: on an edge with dreq or in_if_req high, select the owner, latch address/wdata/type, load wait counter with WAIT-1, go to ACC.
  - ACC: out_ram_en=1 and out_ram_addr = latched address. The counter decrements each cycle.
  - ACC, counter==0: for a store, out_ram_we=1 for this cycle only. On the edge, capture in_ram_rdata into the owner's data register (reads only) and go to ACK.
  - ACK: the owner's ack is high for exactly one cycle. Next state is always IDLE.
- Inputs that change during ACC/ACK are ignored. Latched values are used.
- Priority: data beats fetch, because the older instruction goes first. The fairness rule under Configuration can override this.
- out_stall = dreq & ~(out_mem_ack). It is combinational, so it drops in the ACK cycle of the data access.
- A store ack leaves out_mem_rdata unchanged.
- Reset values: all outputs 0, state IDLE, counter 0, fairness count 0.
- Reset mid-access: the transaction is aborted immediately and asynchronously. out_ram_en/out_ram_we go to 0 and no ack is issued. After release, the held requests are re-arbitrated from IDLE.

## Timing
- A request sampled at edge k drives RAM signals during cycles k+1..k+WAIT.
- Ack is high in cycle k+WAIT+1.
- IDLE is reached in cycle k+WAIT+2, and the earliest next grant is at the edge ending that cycle.
- Throughput: one access per WAIT+2 cycles.
- RAM outputs are registered. out_ram_addr and out_ram_wdata are stable for the whole ACC window.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 2-bit count tracks consecutive data grants made while in_if_req was pending.
  - When the count reaches 2 and both requests are present, fetch is granted and the count clears.
  - The count also clears whenever in_if_req is low at a grant.
- MEM_ARB_FAIR_EN undefined: strict data priority. The counter logic is removed.

## Structure
- Shared package mem_arb_pkg holds:
  - state localparams ST_IDLE, ST_ACC, ST_ACK;
  - owner codes OWN_IF, OWN_DM;
  - FAIR_LIMIT=2.
- One sub-module, mem_arb_wait_cnt: a loadable 4-bit down-counter with a zero flag, using CLOCK and in_rst.

## Test plan
- Fetch only: WAIT=2, in_if_req=1, addr 0x0010, in_ram_rdata=0x1234.
  - out_ram_en=1 for 2 cycles at 0x0010.
  - Then out_if_ack=1 for 1 cycle with out_if_data=0x1234.
- Store: mem_write=1, addr 0x0002, data 0x0004.
  - out_ram_we=1 only in the 2nd ACC cycle, with addr 0x0002 and wdata 0x0004.
  - out_mem_ack pulses once.
  - out_stall is high from request until the ack cycle.
- Contention: load at 0x0002 and fetch at 0x0020 raised in the same cycle.
  - Load is served first and out_mem_rdata gets the RAM value.
  - Fetch is granted at the first IDLE edge after the load's ACK.
- Fairness: three back-to-back loads with in_if_req held.
  - Macro on: grant order D, D, IF, D.
  - Macro off: grant order D, D, D, IF.
- Reset mid-access: in_rst low during the 1st ACC cycle.
  - out_ram_en=0 immediately and no ack is issued.
  - After release, the held requests are re-served with full WAIT latency.
- Read+write both high: a store is performed and out_mem_rdata is unchanged.
